regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (load / multi-cycle unit). It uses round-robin arbitration behind a valid/ready handshake and drives a registered write command into the register file. It also keeps a 32-entry pending-write scoreboard that decode reserves and that committed writes release, so the pipeline can stall on RS/RT operands still in flight. It sits between the execute/memory stages and the register file write inputs.

---
 rtl/regfile_write_arbiter.sv | 98 +++++++++
 tb/tb_regfile_write_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two writeback
// requesters, plus a pending-write scoreboard for operand hazard detection.
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    input  logic              rsv_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic [1:0]        RegWrite_o
);

    localparam int NREG = 1 << ADDR_W;

    logic              last_q, last_d;
    logic              wr_v_q, wr_v_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    // last_q = 1 means B won last, so A takes the next tie
    always_comb begin
        a_ready_o = a_valid_i && (!b_valid_i || last_q);
        b_ready_o = b_valid_i && (!a_valid_i || !last_q);
    end

    always_comb begin
        last_d    = last_q;
        wr_v_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (a_ready_o) begin
            rd_addr_d = a_addr_i;
            rd_data_d = a_data_i;
            wr_v_d    = (a_addr_i != '0);
            last_d    = 1'b0;
        end else if (b_ready_o) begin
            rd_addr_d = b_addr_i;
            rd_data_d = b_data_i;
            wr_v_d    = (b_addr_i != '0);
            last_d    = 1'b1;
        end
    end

    // A reservation is applied last so it survives a same-edge clear or flush
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else if (wr_v_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (rsv_i && (rsv_addr_i != '0)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q    <= 1'b1;
            wr_v_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            last_q    <= last_d;
            wr_v_q    <= wr_v_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        rs_busy_o  = (rs_addr_i != '0) && busy_q[rs_addr_i];
        rt_busy_o  = (rt_addr_i != '0) && busy_q[rt_addr_i];
        RDaddr_o   = rd_addr_q;
        RDdata_o   = rd_data_q;
        RegWrite_o = {wr_v_q, 1'b0};
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grants, write timing, scoreboard.
module tb_regfile_write_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        a_valid_i = 1'b0;
    logic [4:0]  a_addr_i = '0;
    logic [31:0] a_data_i = '0;
    logic        a_ready_o;
    logic        b_valid_i = 1'b0;
    logic [4:0]  b_addr_i = '0;
    logic [31:0] b_data_i = '0;
    logic        b_ready_o;
    logic        rsv_i = 1'b0;
    logic [4:0]  rsv_addr_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  rs_addr_i = '0;
    logic [4:0]  rt_addr_i = '0;
    logic        rs_busy_o;
    logic        rt_busy_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [1:0]  RegWrite_o;

    int nvec = 0;
    int nfail = 0;

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i),
        .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i),
        .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i), .flush_i(flush_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o),
        .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .RegWrite_o(RegWrite_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if (RegWrite_o !== 2'b00) begin
            nfail++;
            $display("FAIL reset_regwrite got %b want 00", RegWrite_o);
        end
        nvec++;
        if (RDaddr_o !== 5'd0 || RDdata_o !== 32'd0) begin
            nfail++;
            $display("FAIL reset_rd got %0d/%h want 0/0", RDaddr_o, RDdata_o);
        end
        nvec++;
        if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0 || rs_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset_ready got %b%b%b want 000", a_ready_o, b_ready_o, rs_busy_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_tie_break();
        a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h11;
        b_valid_i = 1'b1; b_addr_i = 5'd4; b_data_i = 32'h22;
        #1;
        nvec++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0) begin
            nfail++;
            $display("FAIL tie_first got a=%b b=%b want a=1 b=0", a_ready_o, b_ready_o);
        end
        tick();
        a_valid_i = 1'b0;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd3 || RDdata_o !== 32'h11) begin
            nfail++;
            $display("FAIL tie_wr_a got %b/%0d/%h want 10/3/11", RegWrite_o, RDaddr_o, RDdata_o);
        end
        nvec++;
        if (b_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL tie_b_ready got %b want 1", b_ready_o);
        end
        tick();
        b_valid_i = 1'b0;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd4 || RDdata_o !== 32'h22) begin
            nfail++;
            $display("FAIL tie_wr_b got %b/%0d/%h want 10/4/22", RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
        #1;
        nvec++;
        if (RegWrite_o !== 2'b00 || RDaddr_o !== 5'd4 || RDdata_o !== 32'h22) begin
            nfail++;
            $display("FAIL tie_idle got %b/%0d/%h want 00/4/22", RegWrite_o, RDaddr_o, RDdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  pa;
        logic [31:0] pd;
        bit          ga;
        pa = '0;
        pd = '0;
        a_valid_i = 1'b1; a_addr_i = 5'd10; a_data_i = 32'hA10;
        b_valid_i = 1'b1; b_addr_i = 5'd20; b_data_i = 32'hB20;
        for (int i = 0; i < 6; i++) begin
            #1;
            ga = (i % 2 == 0);
            nvec++;
            if (a_ready_o !== ga || b_ready_o !== !ga) begin
                nfail++;
                $display("FAIL b2b_grant%0d got a=%b b=%b want a=%b", i, a_ready_o, b_ready_o, ga);
            end
            if (i > 0) begin
                nvec++;
                if (RegWrite_o !== 2'b10 || RDaddr_o !== pa || RDdata_o !== pd) begin
                    nfail++;
                    $display("FAIL b2b_wr%0d got %b/%0d/%h want 10/%0d/%h",
                             i, RegWrite_o, RDaddr_o, RDdata_o, pa, pd);
                end
            end
            pa = ga ? a_addr_i : b_addr_i;
            pd = ga ? a_data_i : b_data_i;
            tick();
            if (ga) begin
                a_addr_i = a_addr_i + 5'd1;
                a_data_i = a_data_i + 32'd1;
            end else begin
                b_addr_i = b_addr_i + 5'd1;
                b_data_i = b_data_i + 32'd1;
            end
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd22 || RDdata_o !== 32'hB22) begin
            nfail++;
            $display("FAIL b2b_last got %b/%0d/%h want 10/22/b22", RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
        nvec++;
        if (RegWrite_o !== 2'b00) begin
            nfail++;
            $display("FAIL b2b_end got %b want 00", RegWrite_o);
        end
    endtask

    task automatic test_zero_drop();
        a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 32'hDEAD;
        rs_addr_i = 5'd0;
        #1;
        nvec++;
        if (a_ready_o !== 1'b1 || rs_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL zero_ready got %b/%b want 1/0", a_ready_o, rs_busy_o);
        end
        tick();
        a_valid_i = 1'b0;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b00 || rs_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL zero_drop got %b/%b want 00/0", RegWrite_o, rs_busy_o);
        end
    endtask

    task automatic test_scoreboard();
        rsv_i = 1'b1; rsv_addr_i = 5'd7;
        rs_addr_i = 5'd7; rt_addr_i = 5'd7;
        #1;
        nvec++;
        if (rs_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL sb_pre got %b want 0", rs_busy_o);
        end
        tick();
        rsv_i = 1'b0;
        #1;
        nvec++;
        if (rs_busy_o !== 1'b1 || rt_busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL sb_rsv got %b/%b want 1/1", rs_busy_o, rt_busy_o);
        end
        b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h77;
        #1;
        nvec++;
        if (b_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL sb_b_ready got %b want 1", b_ready_o);
        end
        tick();
        b_valid_i = 1'b0;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd7 || rs_busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL sb_commit got %b/%0d/%b want 10/7/1", RegWrite_o, RDaddr_o, rs_busy_o);
        end
        tick();
        #1;
        nvec++;
        if (rs_busy_o !== 1'b0 || RegWrite_o !== 2'b00) begin
            nfail++;
            $display("FAIL sb_release got %b/%b want 0/00", rs_busy_o, RegWrite_o);
        end
    endtask

    task automatic test_collision();
        rsv_i = 1'b1; rsv_addr_i = 5'd5;
        tick();
        rsv_i = 1'b0;
        a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'h55;
        tick();
        a_valid_i = 1'b0;
        rsv_i = 1'b1; rsv_addr_i = 5'd5;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd5) begin
            nfail++;
            $display("FAIL col_commit got %b/%0d want 10/5", RegWrite_o, RDaddr_o);
        end
        tick();
        rsv_i = 1'b0;
        rs_addr_i = 5'd5;
        #1;
        nvec++;
        if (rs_busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL col_rsv_wins got %b want 1", rs_busy_o);
        end
        a_valid_i = 1'b1; a_addr_i = 5'd6; a_data_i = 32'h66;
        rsv_i = 1'b1; rsv_addr_i = 5'd12;
        tick();
        a_valid_i = 1'b0;
        flush_i = 1'b1;
        rsv_addr_i = 5'd9;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || RDaddr_o !== 5'd6 || RDdata_o !== 32'h66) begin
            nfail++;
            $display("FAIL flush_commit got %b/%0d/%h want 10/6/66", RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
        flush_i = 1'b0;
        rsv_i = 1'b0;
        rs_addr_i = 5'd9; rt_addr_i = 5'd12;
        #1;
        nvec++;
        if (rs_busy_o !== 1'b1 || rt_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL flush_rsv got r9=%b r12=%b want 1/0", rs_busy_o, rt_busy_o);
        end
        rs_addr_i = 5'd5; rt_addr_i = 5'd6;
        #1;
        nvec++;
        if (rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL flush_clear got r5=%b r6=%b want 0/0", rs_busy_o, rt_busy_o);
        end
    endtask

    task automatic test_async_reset();
        rsv_i = 1'b1; rsv_addr_i = 5'd8;
        b_valid_i = 1'b1; b_addr_i = 5'd8; b_data_i = 32'h88;
        tick();
        rsv_i = 1'b0;
        b_valid_i = 1'b0;
        rs_addr_i = 5'd9; rt_addr_i = 5'd8;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b10 || rt_busy_o !== 1'b1 || rs_busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL arst_pre got %b/%b/%b want 10/1/1", RegWrite_o, rt_busy_o, rs_busy_o);
        end
        #1;
        rst_i = 1'b1;
        #1;
        nvec++;
        if (RegWrite_o !== 2'b00 || rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL arst_now got %b/%b/%b want 00/0/0", RegWrite_o, rs_busy_o, rt_busy_o);
        end
        nvec++;
        if (RDaddr_o !== 5'd0 || RDdata_o !== 32'd0) begin
            nfail++;
            $display("FAIL arst_rd got %0d/%h want 0/0", RDaddr_o, RDdata_o);
        end
        tick();
        rst_i = 1'b0;
        a_valid_i = 1'b1; a_addr_i = 5'd1;
        b_valid_i = 1'b1; b_addr_i = 5'd2;
        #1;
        nvec++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0) begin
            nfail++;
            $display("FAIL arst_tie got a=%b b=%b want 1/0", a_ready_o, b_ready_o);
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie_break();
        test_back_to_back();
        test_zero_drop();
        test_scoreboard();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
